// File: rtl/calc_operand_entry.sv
`default_nettype none
// ============================================================================
// Module      : calc_operand_entry
// Description : Turns level-type keypad outputs into single-cycle key events,
//               assembles two decimal operands plus an operator, and presents
//               them downstream over a valid/ready handshake. The operand
//               currently being typed is driven to the display path.
//
// Ports       : clk         - system clock
//               reset       - synchronous, active-high reset
//               num         - digit key code, 0-9, valid with numPressed
//               numPressed  - level, high while a digit key is held
//               opt         - operator code 1..5, valid with optPressed
//               optPressed  - level, high while an operator key is held
//               submit      - level, high while the submit key is held
//               req_valid   - calculation request pending
//               req_ready   - downstream accepts when high with req_valid
//               operand_a   - first operand
//               operand_b   - second operand
//               op          - operator code
//               display     - operand currently being entered
//               busy        - high while a request is outstanding
//
// Revision    : 1.0 - initial release
// ============================================================================
module calc_operand_entry #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       num,
    input  logic             numPressed,
    input  logic [2:0]       opt,
    input  logic             optPressed,
    input  logic             submit,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [2:0]       op,
    output logic [WIDTH-1:0] display,
    output logic             busy
);

    localparam int            CW        = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] C_MAX_CNT = CW'(DIGITS);

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_OP    = 2'd1,
        S_B     = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_np_s1, r_np_s2;
    logic             r_opp_s1, r_opp_s2;
    logic             r_sub_s1, r_sub_s2;
    logic [3:0]       r_num_s1;
    logic [2:0]       r_opt_s1;
    logic [WIDTH-1:0] r_a, r_b, r_display;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt_a, r_cnt_b;
    logic             r_req_valid, r_busy;

    // ------------------------------------------------------------------
    // Event detection with priority submit > opt > num
    // ------------------------------------------------------------------
    logic w_sub_raw, w_opt_raw, w_num_raw;
    logic w_sub_ev, w_opt_ev, w_num_ev;
    logic w_opt_ok;

    assign w_sub_raw = r_sub_s1 & ~r_sub_s2;
    assign w_opt_raw = r_opp_s1 & ~r_opp_s2;
    assign w_num_raw = r_np_s1  & ~r_np_s2;

    assign w_sub_ev  = w_sub_raw;
    assign w_opt_ev  = w_opt_raw & ~w_sub_raw;
    // A digit is discarded whenever a higher-priority key edge is present,
    // even if that higher-priority event is itself ignored in this state.
    assign w_num_ev  = w_num_raw & ~w_sub_raw & ~w_opt_raw;

    assign w_opt_ok  = (r_opt_s1 >= 3'd1) && (r_opt_s1 <= 3'd5);

    // ------------------------------------------------------------------
    // Digit append: val*10 + num as shifts and adds, truncated to WIDTH
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_num_ext;
    logic [WIDTH-1:0] w_a_app, w_b_app;
    logic             w_a_inc, w_b_inc;

    assign w_num_ext = WIDTH'(r_num_s1);
    assign w_a_app   = (r_a << 3) + (r_a << 1) + w_num_ext;
    assign w_b_app   = (r_b << 3) + (r_b << 1) + w_num_ext;
    // Leading zeros do not consume a digit position.
    assign w_a_inc   = !((r_num_s1 == 4'd0) && (r_a == '0));
    assign w_b_inc   = !((r_num_s1 == 4'd0) && (r_b == '0));

    // ------------------------------------------------------------------
    // Next-state / next-operand logic
    // ------------------------------------------------------------------
    state_t           w_state_nx;
    logic [WIDTH-1:0] w_a_nx, w_b_nx, w_display_nx;
    logic [2:0]       w_op_nx;
    logic [CW-1:0]    w_cnt_a_nx, w_cnt_b_nx;

    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_op_nx    = r_op;
        w_cnt_a_nx = r_cnt_a;
        w_cnt_b_nx = r_cnt_b;

        case (r_state)
            S_A: begin
                if (w_opt_ev && w_opt_ok) begin
                    w_op_nx    = r_opt_s1;
                    w_state_nx = S_OP;
                end else if (w_num_ev && (r_cnt_a != C_MAX_CNT)) begin
                    w_a_nx = w_a_app;
                    if (w_a_inc) begin
                        w_cnt_a_nx = r_cnt_a + 1'b1;
                    end
                end
            end

            S_OP: begin
                if (w_sub_ev) begin
                    w_b_nx     = '0;
                    w_cnt_b_nx = '0;
                    w_state_nx = S_ISSUE;
                end else if (w_opt_ev && w_opt_ok) begin
                    w_op_nx = r_opt_s1;
                end else if (w_num_ev) begin
                    w_b_nx     = w_num_ext;
                    w_cnt_b_nx = CW'(r_num_s1 != 4'd0);
                    w_state_nx = S_B;
                end
            end

            S_B: begin
                if (w_sub_ev) begin
                    w_state_nx = S_ISSUE;
                end else if (w_num_ev && (r_cnt_b != C_MAX_CNT)) begin
                    w_b_nx = w_b_app;
                    if (w_b_inc) begin
                        w_cnt_b_nx = r_cnt_b + 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                // Keys are ignored; only the handshake can leave this state.
                if (r_req_valid && req_ready) begin
                    w_state_nx = S_A;
                    w_a_nx     = '0;
                    w_b_nx     = '0;
                    w_op_nx    = '0;
                    w_cnt_a_nx = '0;
                    w_cnt_b_nx = '0;
                end
            end

            default: begin
                w_state_nx = S_A;
            end
        endcase

        // Display follows the operand of the state being entered, so it is
        // coherent with operand_a/operand_b in the same cycle.
        if ((w_state_nx == S_A) || (w_state_nx == S_OP)) begin
            w_display_nx = w_a_nx;
        end else begin
            w_display_nx = w_b_nx;
        end
    end

    // ------------------------------------------------------------------
    // State, history and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_A;
            r_np_s1     <= 1'b0;
            r_np_s2     <= 1'b0;
            r_opp_s1    <= 1'b0;
            r_opp_s2    <= 1'b0;
            r_sub_s1    <= 1'b0;
            r_sub_s2    <= 1'b0;
            r_num_s1    <= '0;
            r_opt_s1    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
            r_display   <= '0;
            r_req_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_np_s1     <= numPressed;
            r_np_s2     <= r_np_s1;
            r_opp_s1    <= optPressed;
            r_opp_s2    <= r_opp_s1;
            r_sub_s1    <= submit;
            r_sub_s2    <= r_sub_s1;
            r_num_s1    <= num;
            r_opt_s1    <= opt;
            r_state     <= w_state_nx;
            r_a         <= w_a_nx;
            r_b         <= w_b_nx;
            r_op        <= w_op_nx;
            r_cnt_a     <= w_cnt_a_nx;
            r_cnt_b     <= w_cnt_b_nx;
            r_display   <= w_display_nx;
            r_req_valid <= (w_state_nx == S_ISSUE);
            r_busy      <= (w_state_nx == S_ISSUE);
        end
    end

    assign req_valid = r_req_valid;
    assign busy      = r_busy;
    assign operand_a = r_a;
    assign operand_b = r_b;
    assign op        = r_op;
    assign display   = r_display;

endmodule
`default_nettype wire

// File: doc/calc_operand_entry.md
Name: calc_operand_entry

Overview:
Sits directly downstream of the keypad decoder. Consumes its level-type key outputs (num/numPressed, opt/optPressed, submit) and turns each key press into a single event. Assembles two decimal operands and an operator from those events, then presents them to the arithmetic/music stage over a valid/ready handshake. Also drives the value currently being typed to the display path.

Parameters:
DIGITS, 4, maximum decimal digits per operand
WIDTH, 14, operand bit width; must hold 10^DIGITS-1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
num  input  4  key code from decoder, 0-9 valid when numPressed
numPressed  input  1  level, high while a digit key is held
opt  input  3  operator code 1..5, valid when optPressed
optPressed  input  1  level, high while an operator key is held
submit  input  1  level, high while the submit key is held
req_valid  output  1  calculation request pending
req_ready  input  1  downstream accepts the request when high with req_valid
operand_a  output  WIDTH  first operand
operand_b  output  WIDTH  second operand
op  output  3  operator code
display  output  WIDTH  operand currently being entered
busy  output  1  high in S_ISSUE

Behaviour:
- Reset: synchronous, active-high; clk is the only clock. All outputs and registers go to 0, state goes to S_A, and the input history registers clear. A reset during S_ISSUE drops req_valid at the same edge.
- Input stage: at each edge, register numPressed/optPressed/submit into stage1 (s1) and s1 into stage2 (s2). num and opt are captured with s1.
- Edge detect: an event is s1 & ~s2. Each event is one clk wide per press, however long the key is held. State and operands update at the following edge. A key high at edge k therefore changes outputs after edge k+1.
- Simultaneous events: priority is submit > opt > num. Lower-priority events in the same cycle are discarded.
- Digit update: val <= val*10 + num, computed as (val<<3)+(val<<1)+num and truncated to WIDTH.
- Digit counter cnt per operand:
  - A digit event with cnt==DIGITS is ignored; the value is unchanged.
  - A 0 entered while val==0 does not increment cnt (leading zero).
- States:
  - S_A: a digit updates operand_a. An opt event stores op and moves to S_OP. Submit is ignored.
  - S_OP: an opt event replaces op. A digit sets operand_b=num, sets cnt_b=(num!=0), and moves to S_B. Submit moves to S_ISSUE with operand_b=0.
  - S_B: a digit updates operand_b. An opt event is ignored. Submit moves to S_ISSUE.
  - S_ISSUE: req_valid=1, busy=1, and all key events are ignored. operand_a, operand_b and op stay stable while req_valid is high. When req_valid&req_ready are sampled at an edge, the next state is S_A and operand_a, operand_b, op and both counters clear to 0. req_valid falls at that same edge.
- A ready that is already high on entry to S_ISSUE gives a one-cycle request.
- display: operand_a in S_A/S_OP, operand_b in S_B/S_ISSUE, registered.
- An opt code of 0 or outside 1..5 with an opt event is ignored.

Test Plan:
- Reset, then hold digit keys 1,2,3 for 5 cycles each with 3-cycle gaps -> operand_a=123, display=123, one update per press.
- Press 5,0,0,0,7 (DIGITS=4) -> operand_a=5000; the fifth digit is ignored. Then press 0,0,4 from reset -> operand_a=4 with cnt=1.
- Press 1,2, opt=3, opt=1, 9, submit with req_ready=0 for 4 cycles then 1 -> req_valid stays high exactly until the accepting edge with a=12, b=9, op=1. Afterwards state is S_A and all fields are 0.
- Press 8, opt=2, submit with req_ready tied high -> one-cycle req_valid with a=8, b=0, op=2. Key presses during S_ISSUE have no effect.
- Assert numPressed and submit rising in the same cycle in S_B -> submit wins and the digit is discarded. Assert reset while req_valid=1 -> req_valid=0 and all outputs 0 after that edge.
